// File: rtl/keccak_pkg.sv
// rtl/keccak_pkg.sv - shared widths, FSM states and byte merge helper for the Keccak byte packer
package keccak_pkg;

   localparam int WORD_W     = 32;
   localparam int BYTE_W     = 8;
   localparam int BYTE_NUM_W = 2;

   typedef enum logic {
      COLLECT = 1'b0,
      PAD     = 1'b1
   } state_t;

   // Holding bytes sit left-justified; the new byte lands just after the last held one.
   function automatic logic [WORD_W-1:0] merge_byte(
      input logic [WORD_W-BYTE_W-1:0] held,
      input logic [BYTE_NUM_W-1:0]    count,
      input logic [BYTE_W-1:0]        data
   );
      return {held, {BYTE_W{1'b0}}} | ({data, {(WORD_W-BYTE_W){1'b0}}} >> {count, 3'b000});
   endfunction

endpackage

// File: rtl/keccak_byte_packer.sv
// rtl/keccak_byte_packer.sv - packs a byte stream into 32-bit words with last-word padding
module keccak_byte_packer
   import keccak_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic [BYTE_W-1:0]     byte_in,
   input  logic                  byte_valid,
   input  logic                  byte_last,
   output logic                  byte_ready,
   output logic [WORD_W-1:0]     in,
   output logic                  in_ready,
   output logic                  is_last,
   output logic [BYTE_NUM_W-1:0] byte_num,
   input  logic                  buffer_full
);

   state_t                     state;
   logic [WORD_W-BYTE_W-1:0]   held;
   logic [BYTE_NUM_W-1:0]      count;
   logic [WORD_W-1:0]          merged;
   logic                       word_take;
   logic                       byte_take;
   logic                       slot_free;

   assign slot_free  = !in_ready || !buffer_full;
   assign word_take  = in_ready && !buffer_full;
   assign byte_ready = (state == COLLECT) && slot_free;
   assign byte_take  = byte_valid && byte_ready;
   assign merged     = merge_byte(held, count, byte_in);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= COLLECT;
         held     <= '0;
         count    <= '0;
         in       <= '0;
         in_ready <= 1'b0;
         is_last  <= 1'b0;
         byte_num <= '0;
      end else begin
         // A load below overrides this, giving back-to-back words with no bubble.
         if (word_take)
            in_ready <= 1'b0;
         case (state)
            COLLECT: begin
               if (byte_take) begin
                  if (count == 2'd3 || byte_last) begin
                     in       <= merged;
                     in_ready <= 1'b1;
                     held     <= '0;
                     count    <= '0;
                     if (count == 2'd3) begin
                        is_last  <= 1'b0;
                        byte_num <= '0;
                        // A full final word still owes the zero terminator word.
                        if (byte_last)
                           state <= PAD;
                     end else begin
                        is_last  <= 1'b1;
                        byte_num <= count + 2'd1;
                     end
                  end else begin
                     held  <= merged[WORD_W-1:BYTE_W];
                     count <= count + 2'd1;
                  end
               end
            end
            PAD: begin
               if (slot_free) begin
                  in       <= '0;
                  is_last  <= 1'b1;
                  byte_num <= '0;
                  in_ready <= 1'b1;
                  state    <= COLLECT;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_keccak_byte_packer.sv
// tb/tb_keccak_byte_packer.sv - directed self-checking bench for keccak_byte_packer
module tb_keccak_byte_packer;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [7:0]  byte_in = 8'h00;
   logic        byte_valid = 1'b0;
   logic        byte_last = 1'b0;
   logic        byte_ready;
   logic [31:0] in;
   logic        in_ready;
   logic        is_last;
   logic [1:0]  byte_num;
   logic        buffer_full = 1'b0;

   int errors = 0;
   int checks = 0;
   logic [34:0] words[$];

   keccak_byte_packer dut (
      .clk(clk), .reset(reset), .byte_in(byte_in), .byte_valid(byte_valid),
      .byte_last(byte_last), .byte_ready(byte_ready), .in(in), .in_ready(in_ready),
      .is_last(is_last), .byte_num(byte_num), .buffer_full(buffer_full)
   );

   always #5 clk = ~clk;

   always @(negedge clk)
      if (reset && in_ready && !buffer_full)
         words.push_back({in, is_last, byte_num});

   task automatic send_byte(input logic [7:0] b, input logic last);
      int n = 0;
      byte_in = b; byte_valid = 1'b1; byte_last = last;
      @(negedge clk);
      while (!byte_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (!byte_ready) begin
         errors++;
         $display("FAIL send_timeout byte=%h byte_ready=%b required 1", b, byte_ready);
      end
      @(posedge clk); #1;
      byte_valid = 1'b0; byte_last = 1'b0;
   endtask

   task automatic send_msg(input string s, input logic last);
      for (int i = 0; i < s.len(); i++)
         send_byte(s[i], last && (i == s.len() - 1));
   endtask

   task automatic settle();
      repeat (6) @(posedge clk);
      #1;
   endtask

   task automatic check_words(input string name, input logic [34:0] exp[$]);
      checks++;
      if (words.size() != exp.size()) begin
         errors++;
         $display("FAIL %s_count got=%0d required=%0d", name, words.size(), exp.size());
      end
      for (int i = 0; i < exp.size() && i < words.size(); i++) begin
         checks++;
         if (words[i] !== exp[i]) begin
            errors++;
            $display("FAIL %s_word%0d got in=%h last=%b num=%0d required in=%h last=%b num=%0d",
                     name, i, words[i][34:3], words[i][2], words[i][1:0],
                     exp[i][34:3], exp[i][2], exp[i][1:0]);
         end
      end
      words.delete();
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({in, in_ready, is_last, byte_num} !== 36'h0) begin
         errors++;
         $display("FAIL reset_outputs got=%h required=0", {in, in_ready, is_last, byte_num});
      end
      checks++;
      if (byte_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_byte_ready got=%b required=1", byte_ready);
      end
      reset = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_hello();
      send_msg("Hello, world!", 1'b1);
      settle();
      check_words("hello", '{{32'h48656C6C, 3'b000}, {32'h6F2C2077, 3'b000},
                             {32'h6F726C64, 3'b000}, {32'h21000000, 3'b101}});
   endtask

   task automatic test_pad();
      send_msg("Hello, world", 1'b1);
      checks++;
      if (byte_ready !== 1'b0 || in !== 32'h6F726C64) begin
         errors++;
         $display("FAIL pad_enter byte_ready=%b in=%h required 0 and 6f726c64", byte_ready, in);
      end
      @(posedge clk); #1;
      checks++;
      if (byte_ready !== 1'b1 || in !== 32'h0 || is_last !== 1'b1 || byte_num !== 2'd0) begin
         errors++;
         $display("FAIL pad_word byte_ready=%b in=%h last=%b num=%0d required 1 0 1 0",
                  byte_ready, in, is_last, byte_num);
      end
      settle();
      check_words("pad", '{{32'h48656C6C, 3'b000}, {32'h6F2C2077, 3'b000},
                           {32'h6F726C64, 3'b000}, {32'h00000000, 3'b100}});
   endtask

   task automatic test_stall();
      send_msg("5678", 1'b0);
      words.delete();
      buffer_full = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (in !== 32'h35363738 || in_ready !== 1'b1 || byte_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold%0d in=%h in_ready=%b byte_ready=%b required 35363738 1 0",
                     i, in, in_ready, byte_ready);
         end
      end
      @(posedge clk); #1;
      buffer_full = 1'b0;
      send_msg("90", 1'b1);
      settle();
      check_words("stall", '{{32'h35363738, 3'b000}, {32'h39300000, 3'b110}});
   endtask

   task automatic test_single();
      send_byte("a", 1'b1);
      checks++;
      if (in_ready !== 1'b1 || in !== 32'h61000000 || is_last !== 1'b1 || byte_num !== 2'd1) begin
         errors++;
         $display("FAIL single in_ready=%b in=%h last=%b num=%0d required 1 61000000 1 1",
                  in_ready, in, is_last, byte_num);
      end
      settle();
      words.delete();
   endtask

   task automatic test_reset_mid();
      send_msg("The qu", 1'b0);
      reset = 1'b0;
      #1;
      checks++;
      if (in !== 32'h0 || in_ready !== 1'b0 || is_last !== 1'b0 || byte_num !== 2'd0) begin
         errors++;
         $display("FAIL reset_mid in=%h in_ready=%b last=%b num=%0d required all 0",
                  in, in_ready, is_last, byte_num);
      end
      @(posedge clk); #1;
      reset = 1'b1;
      words.delete();
      send_msg("dog.", 1'b1);
      settle();
      check_words("dog", '{{32'h646F672E, 3'b000}, {32'h00000000, 3'b100}});
   endtask

   task automatic test_back_to_back();
      send_msg("abc", 1'b1);
      send_msg("xyz", 1'b1);
      settle();
      check_words("b2b", '{{32'h61626300, 3'b111}, {32'h78797A00, 3'b111}});
   endtask

   initial begin
      test_reset();
      test_hello();
      test_pad();
      send_msg("1234", 1'b0);
      words.delete();
      test_stall();
      test_single();
      test_reset_mid();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
